// File: rtl/counter_ctrl_if.sv
// Button inputs and counter-control outputs between the panel and counter_ctrl.
interface counter_ctrl_if;
  logic btn_run;
  logic btn_dir;
  logic btn_step;
  logic enable;
  logic direction;
  logic running;

  modport master (
    output btn_run, btn_dir, btn_step,
    input  enable, direction, running
  );

  modport slave (
    input  btn_run, btn_dir, btn_step,
    output enable, direction, running
  );
endinterface

// File: rtl/counter_ctrl.sv
// Run/stop/step/direction control for an up/down counter, driven by three
// raw push-buttons that are synchronized, debounced and turned into press events.
module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic          clk_reg,
  input  logic          rst,
  counter_ctrl_if.slave bus
);

  localparam int unsigned NBTN   = 3;
  localparam int unsigned CW     = 8;
  localparam int unsigned B_RUN  = 0;
  localparam int unsigned B_DIR  = 1;
  localparam int unsigned B_STEP = 2;

  typedef enum logic [1:0] {STOPPED, RUN, STEP} state_t;

  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] armed;
  logic [NBTN-1:0] press;
  logic [CW-1:0]   cnt [NBTN];
  logic [1:0]      settle;

  state_t state;
  state_t next_state;
  logic   en_reg;
  logic   run_reg;
  logic   dir_reg;

  assign raw = {bus.btn_step, bus.btn_dir, bus.btn_run};

  // Two-flop synchronizers; settle marks when sync2 holds a real post-reset sample.
  always_ff @(posedge clk_reg or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      settle <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      settle <= {settle[0], 1'b1};
    end
  end

  // Debounce; a button only produces events once it has been seen low after reset.
  always_ff @(posedge clk_reg or posedge rst) begin
    if (rst) begin
      level <= '0;
      armed <= '0;
      press <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        press[i] <= 1'b0;
        if (settle[1] && !sync2[i]) armed[i] <= 1'b1;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          press[i] <= sync2[i] & armed[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_reg or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= next_state;
  end

  // Run wins over step when both arrive together in STOPPED.
  always_comb begin
    next_state = state;
    case (state)
      STOPPED: begin
        if (press[B_RUN])       next_state = RUN;
        else if (press[B_STEP]) next_state = STEP;
      end
      RUN: begin
        if (press[B_RUN]) next_state = STOPPED;
      end
      STEP:    next_state = STOPPED;
      default: next_state = STOPPED;
    endcase
  end

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk_reg or posedge rst) begin
    if (rst) begin
      en_reg  <= 1'b0;
      run_reg <= 1'b0;
      dir_reg <= 1'b1;
    end else begin
      en_reg  <= (next_state != STOPPED);
      run_reg <= (next_state == RUN);
      dir_reg <= dir_reg ^ press[B_DIR];
    end
  end

  assign bus.enable    = en_reg;
  assign bus.running   = run_reg;
  assign bus.direction = dir_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: vector table, directed corner sequences
// and random button activity compared every cycle against a reference model.
module tb_counter_ctrl;

  localparam int unsigned D = 4;

  logic clk_reg = 1'b0;
  logic rst     = 1'b1;

  counter_ctrl_if bus ();

  counter_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_reg (clk_reg),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_reg = ~clk_reg;

  int checks = 0;
  int errors = 0;

  // Reference model: button sample history, debounced levels and the
  // run/stop/step rules applied to press events one edge after they occur.
  bit  rawq [3][$];
  bit  smpq [3][$];
  bit  m_lvl  [3] = '{0, 0, 0};
  bit  m_arm  [3] = '{0, 0, 0};
  bit  m_ev   [3] = '{0, 0, 0};
  int  m_last [3] = '{0, 0, 0};
  int  m_n     = 0;
  int  m_state = 0;  // 0 stopped, 1 run, 2 step
  bit  m_dir   = 1'b1;

  always @(posedge clk_reg or posedge rst) begin : model
    bit raw_now [3];
    bit nev [3];
    bit s;
    bit flip;
    int sz;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        rawq[b].delete();
        smpq[b].delete();
        m_lvl[b]  = 1'b0;
        m_arm[b]  = 1'b0;
        m_ev[b]   = 1'b0;
        m_last[b] = 0;
      end
      m_n     = 0;
      m_state = 0;
      m_dir   = 1'b1;
    end else begin
      m_n = m_n + 1;
      if (m_state == 2)                  m_state = 0;
      else if (m_state == 0 && m_ev[0])  m_state = 1;
      else if (m_state == 0 && m_ev[2])  m_state = 2;
      else if (m_state == 1 && m_ev[0])  m_state = 0;
      if (m_ev[1]) m_dir = ~m_dir;

      raw_now[0] = bus.btn_run;
      raw_now[1] = bus.btn_dir;
      raw_now[2] = bus.btn_step;
      for (int b = 0; b < 3; b++) begin
        rawq[b].push_back(raw_now[b]);
        s = (m_n >= 3) ? rawq[b][m_n - 3] : 1'b0;
        smpq[b].push_back(s);
        sz   = smpq[b].size();
        flip = (m_n - m_last[b] >= int'(D));
        for (int k = 0; k < int'(D); k++)
          if (flip && smpq[b][sz - 1 - k] == m_lvl[b]) flip = 1'b0;
        nev[b] = flip && !m_lvl[b] && m_arm[b];
        if (flip) begin
          m_lvl[b]  = ~m_lvl[b];
          m_last[b] = m_n;
        end
        if (m_n >= 3 && !s) m_arm[b] = 1'b1;
      end
      m_ev = nev;
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0b exp=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance n edges, comparing all outputs with the model after each one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_reg);
      chk("model_enable",    bus.enable,    m_state != 0);
      chk("model_running",   bus.running,   m_state == 1);
      chk("model_direction", bus.direction, m_dir);
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic s);
    bus.btn_run  = r;
    bus.btn_dir  = d;
    bus.btn_step = s;
  endtask

  typedef struct {
    logic run;
    logic dir;
    logic step;
    int   cyc;
    logic en;
    logic dr;
    logic rn;
  } vec_t;

  vec_t tbl [$];

  initial begin
    drive(1'b0, 1'b0, 1'b0);

    tbl.push_back('{1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  3, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,  5, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0});

    // Reset state
    repeat (3) @(negedge clk_reg);
    chk("rst_enable",    bus.enable,    1'b0);
    chk("rst_running",   bus.running,   1'b0);
    chk("rst_direction", bus.direction, 1'b1);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].dir, tbl[i].step);
      tick(tbl[i].cyc);
      chk($sformatf("vec%0d_enable", i),    bus.enable,    tbl[i].en);
      chk($sformatf("vec%0d_direction", i), bus.direction, tbl[i].dr);
      chk($sformatf("vec%0d_running", i),   bus.running,   tbl[i].rn);
    end

    // Run press latency: reacts on edge D+3 after the first sampling edge
    drive(1'b1, 1'b0, 1'b0);
    tick(6);
    chk("run_lat_e6", bus.running, 1'b0);
    tick(1);
    chk("run_lat_e7", bus.running, 1'b1);
    chk("run_lat_e7_en", bus.enable, 1'b1);
    tick(3);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);
    drive(1'b1, 1'b0, 1'b0);
    tick(6);
    chk("stop_lat_e6", bus.running, 1'b1);
    tick(1);
    chk("stop_lat_e7", bus.running, 1'b0);
    chk("stop_lat_e7_en", bus.enable, 1'b0);
    tick(3);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);

    // Single step: enable high for exactly one cycle
    drive(1'b0, 1'b0, 1'b1);
    tick(6);
    chk("step_e6", bus.enable, 1'b0);
    tick(1);
    chk("step_e7", bus.enable, 1'b1);
    chk("step_e7_running", bus.running, 1'b0);
    tick(1);
    chk("step_e8", bus.enable, 1'b0);
    tick(2);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);
    chk("step_after", bus.enable, 1'b0);

    // Reset mid-run with run still held
    drive(1'b1, 1'b0, 1'b0);
    tick(10);
    chk("pre_rst_running", bus.running, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_enable",    bus.enable,    1'b0);
    chk("async_rst_running",   bus.running,   1'b0);
    chk("async_rst_direction", bus.direction, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(20);
    chk("held_after_rst", bus.running, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);
    drive(1'b1, 1'b0, 1'b0);
    tick(10);
    chk("repress_after_rst", bus.running, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);

    // Random button activity against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) bus.btn_run  = ~bus.btn_run;
      if ($urandom_range(0, 5) == 0) bus.btn_dir  = ~bus.btn_dir;
      if ($urandom_range(0, 5) == 0) bus.btn_step = ~bus.btn_step;
      tick(1);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a new button level (legal range 2..255).
REQ-002 clk_reg  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 btn_run  input  1  raw, asynchronous run/stop push-button, high = pressed.
REQ-005 btn_dir  input  1  raw, asynchronous direction push-button, high = pressed.
REQ-006 btn_step  input  1  raw, asynchronous single-step push-button, high = pressed.
REQ-007 enable  output  1  count enable to the downstream up/down counter.
REQ-008 direction  output  1  count direction to the downstream counter; 1 = up, 0 = down.
REQ-009 running  output  1  high while the FSM is in RUN.

Function
REQ-010 Each button input SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each synchronized button SHALL have an 8-bit debounce counter:
  - counter clears on any edge where the synchronized sample equals the debounced level;
  - otherwise it increments;
  - on the edge where it reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
REQ-012 A press event SHALL be a registered one-cycle pulse, asserted the cycle after the debounced level goes 0->1; releases SHALL generate no event.
REQ-013 Latency: with a raw input held high, the output reaction to a press event SHALL occur on rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples the high input as edge 1.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no event.
REQ-015 A direction register SHALL toggle on every btn_dir press event, independent of FSM state; direction SHALL equal this register.
REQ-016 FSM states:
  - STOPPED: enable=0;
  - RUN: enable=1;
  - STEP: enable=1 for exactly one cycle.
REQ-017 STOPPED -> RUN on a btn_run event.
REQ-018 RUN -> STOPPED on a btn_run event.
REQ-019 STOPPED -> STEP on a btn_step event; STEP -> STOPPED unconditionally on the next edge.
REQ-020 btn_step events in RUN or STEP SHALL be ignored; btn_run events in STEP SHALL be ignored.
REQ-021 Simultaneous btn_run and btn_step events in STOPPED SHALL go to RUN; the step SHALL be discarded.
REQ-022 A btn_dir event coincident with any FSM transition SHALL toggle direction on the same edge; both changes are visible together.
REQ-023 enable, direction and running SHALL be driven directly from registers, with no combinational path from inputs.
REQ-024 Holding any button indefinitely SHALL produce exactly one event per press.

Reset
REQ-025 While rst=1, the following SHALL hold immediately and independent of clk_reg:
  - FSM = STOPPED, so enable=0 and running=0;
  - direction=1 (count up);
  - synchronizer flops, debounced levels, debounce counters and event pulses all 0.
REQ-026 Reset asserted mid-operation (RUN, STEP or mid-debounce) SHALL abort it; no event SHALL be generated on release of reset, even if a button is still held.
REQ-027 After rst deasserts, a held button SHALL register as a press only after being seen low and then high again.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset then idle 20 cycles -> enable=0, direction=1, running=0 throughout.
REQ-029 btn_run high from edge 1 for 10 cycles -> enable=1 and running=1 from edge 7; second press -> both 0 seven edges after its first sampled edge.
REQ-030 btn_step press in STOPPED -> enable=1 for exactly one cycle, then 0; a step press while RUN -> enable stays 1, no state change.
REQ-031 btn_dir pulse of 3 cycles, then a 10-cycle press -> first pulse ignored; direction 1->0 once, at edge 7 of the long press.
REQ-032 btn_run and btn_step rise on the same edge in STOPPED -> RUN entered, no STEP cycle.
REQ-033 rst pulsed while RUN with btn_run held -> enable=0 immediately; after release, FSM stays in STOPPED until btn_run goes low and is pressed again.
